// File: rtl/ldtu_lane_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// ldtu_pkg
// Shared definitions for the LiTE-DTU lane dispatcher:
//   - mode encoding reported on the dispatcher's mode output
//   - state enum used by the frame-synchronous mode machine
//   - byte patterns replicated into SYNC and IDLE lane words
// ---------------------------------------------------------------------------
package ldtu_pkg;

    localparam logic [1:0] MODE_SYNC = 2'd0;
    localparam logic [1:0] MODE_RUN  = 2'd1;
    localparam logic [1:0] MODE_TEST = 2'd2;
    localparam logic [1:0] MODE_CAL  = 2'd3;

    typedef enum logic [1:0] {
        ST_SYNC = MODE_SYNC,
        ST_RUN  = MODE_RUN,
        ST_TEST = MODE_TEST,
        ST_CAL  = MODE_CAL
    } disp_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h5A;
    localparam logic [7:0] IDLE_BYTE = 8'hE1;

endpackage

// File: rtl/ldtu_lane_dispatcher_if.sv
// ---------------------------------------------------------------------------
// ldtu_lane_dispatcher_if
// Valid/ready word stream from the output storage FIFO into the dispatcher.
//   in_data  : NBITS word
//   in_valid : in_data is valid (driven by the FIFO side)
//   in_ready : word accepted on a clock edge with in_valid & in_ready
// Modports: master = FIFO side, slave = dispatcher side.
// ---------------------------------------------------------------------------
interface ldtu_lane_dispatcher_if #(
    parameter int NBITS = 32
) ();
    logic [NBITS-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ldtu_disp_stage.sv
// ---------------------------------------------------------------------------
// ldtu_disp_stage
// Staging buffer for one frame: up to NLANES words plus a fill count.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset (clears fill only)
//   wr_en     : store wr_data at stage[fill] and increment fill
//   wr_data   : word to store
//   clr       : empty the buffer (frame edge); wins over wr_en
//   stage     : buffered words, lane order
//   fill      : number of valid words (0..NLANES)
//   full      : fill == NLANES
// ---------------------------------------------------------------------------
module ldtu_disp_stage #(
    parameter int NBITS  = 32,
    parameter int NLANES = 4,
    parameter int FILL_W = $clog2(NLANES + 1)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           wr_en,
    input  logic [NBITS-1:0]               wr_data,
    input  logic                           clr,
    output logic [NLANES-1:0][NBITS-1:0]   stage,
    output logic [FILL_W-1:0]              fill,
    output logic                           full
);

    assign full = (fill == FILL_W'(NLANES));

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            fill <= '0;
        end else if (wr_en && !full) begin
            fill <= fill + FILL_W'(1);
        end
    end

    // Data needs no reset: anything beyond fill is never read.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NLANES; i++) begin
            if (wr_en && !full && (fill == FILL_W'(i))) begin
                stage[i] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/ldtu_lane_dispatcher.sv
// ---------------------------------------------------------------------------
// ldtu_lane_dispatcher
// Output-stage dispatcher: collects FIFO words into a staging buffer and
// loads NLANES serializer lanes once per frame of FRAME_DIV cycles. A
// frame-synchronous mode machine selects live data (RUN), ATU patterns
// (TEST), sync words (SYNC) or idle words (CAL).
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   in_if (slave)     : in_data / in_valid / in_ready word stream
//   CALIBRATION_BUSY  : ADC calibration in progress (sampled at frame edge)
//   TEST_ENABLE       : ATU test-pattern request (sampled at frame edge)
//   handshake         : back-end link-lock acknowledge (sampled at frame edge)
//   DATA_ATU          : test patterns, lane i at [i*NBITS +: NBITS]
//   DATA_OUT          : registered lane words, lane i at [i*NBITS +: NBITS]
//   lane_valid        : bit i set when lane i carries a FIFO word
//   frame_stb         : pulse in the first cycle new DATA_OUT is visible
//   mode              : 0 SYNC, 1 RUN, 2 TEST, 3 CAL
// Optional feature: define LDTU_DISP_IDLECNT_EN to put an 8-bit frame
// number in bits [7:0] of every IDLE word.
// ---------------------------------------------------------------------------
module ldtu_lane_dispatcher
    import ldtu_pkg::*;
#(
    parameter int NBITS     = 32,
    parameter int NLANES    = 4,
    parameter int FRAME_DIV = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    ldtu_lane_dispatcher_if.slave    in_if,
    input  logic                     CALIBRATION_BUSY,
    input  logic                     TEST_ENABLE,
    input  logic                     handshake,
    input  logic [NLANES*NBITS-1:0]  DATA_ATU,
    output logic [NLANES*NBITS-1:0]  DATA_OUT,
    output logic [NLANES-1:0]        lane_valid,
    output logic                     frame_stb,
    output logic [1:0]               mode
);

    localparam int CNT_W  = $clog2(FRAME_DIV);
    localparam int FILL_W = $clog2(NLANES + 1);
    localparam logic [NBITS-1:0] SYNC_WORD = {(NBITS/8){SYNC_BYTE}};
    localparam logic [NBITS-1:0] IDLE_PAT  = {(NBITS/8){IDLE_BYTE}};

    if ((NBITS % 8) != 0 || NBITS < 16) begin : g_bad_nbits
        $error("NBITS must be a multiple of 8 and at least 16");
    end
    if (NLANES < 1 || NLANES > 8) begin : g_bad_nlanes
        $error("NLANES must be in 1..8");
    end
    if (FRAME_DIV < NLANES + 1) begin : g_bad_div
        $error("FRAME_DIV must be at least NLANES+1");
    end

    disp_state_t                  state;
    logic                         locked;
    logic [CNT_W-1:0]             fcnt;
    logic                         frame_edge;
    logic [NLANES-1:0][NBITS-1:0] stage;
    logic [FILL_W-1:0]            fill;
    logic                         full;
    logic                         wr_en;
    logic [NBITS-1:0]             idle_word;
    logic [NLANES*NBITS-1:0]      next_out;
    logic [NLANES-1:0]            next_valid;

    assign frame_edge = (fcnt == CNT_W'(FRAME_DIV - 1));

    // Registers only: never looks at in_valid. Closing on the edge cycle
    // keeps every word inside a single frame.
    assign in_if.in_ready = (state == ST_RUN) && !full && !frame_edge;
    assign wr_en          = in_if.in_valid && in_if.in_ready;

    always_ff @(posedge CLK) begin
        if (RST || frame_edge) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + CNT_W'(1);
        end
    end

    ldtu_disp_stage #(
        .NBITS  (NBITS),
        .NLANES (NLANES),
        .FILL_W (FILL_W)
    ) u_stage (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (wr_en),
        .wr_data (in_if.in_data),
        .clr     (frame_edge),
        .stage   (stage),
        .fill    (fill),
        .full    (full)
    );

`ifdef LDTU_DISP_IDLECNT_EN
    // Frame number of the frame being loaded; steps on every frame edge.
    logic [7:0] frame_num;

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_num <= 8'd0;
        end else if (frame_edge) begin
            frame_num <= frame_num + 8'd1;
        end
    end

    assign idle_word = {IDLE_PAT[NBITS-1:8], frame_num};
`else
    assign idle_word = IDLE_PAT;
`endif

    // Lane contents for the frame about to be loaded.
    always_comb begin
        next_out   = '0;
        next_valid = '0;
        for (int i = 0; i < NLANES; i++) begin
            case (state)
                ST_RUN: begin
                    if (FILL_W'(i) < fill) begin
                        next_out[i*NBITS +: NBITS] = stage[i];
                        next_valid[i]              = 1'b1;
                    end else begin
                        next_out[i*NBITS +: NBITS] = idle_word;
                    end
                end
                ST_TEST: next_out[i*NBITS +: NBITS] = DATA_ATU[i*NBITS +: NBITS];
                ST_SYNC: next_out[i*NBITS +: NBITS] = SYNC_WORD;
                default: next_out[i*NBITS +: NBITS] = idle_word;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_OUT   <= {NLANES{SYNC_WORD}};
            lane_valid <= '0;
            frame_stb  <= 1'b0;
        end else begin
            frame_stb <= frame_edge;
            if (frame_edge) begin
                DATA_OUT   <= next_out;
                lane_valid <= next_valid;
            end
        end
    end

    // Mode machine: inputs only matter at the frame edge. Calibration drops
    // the lock so RUN needs a fresh handshake afterwards; TEST keeps it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_SYNC;
            locked <= 1'b0;
        end else if (frame_edge) begin
            if (CALIBRATION_BUSY) begin
                state  <= ST_CAL;
                locked <= 1'b0;
            end else if (TEST_ENABLE) begin
                state <= ST_TEST;
            end else if (locked) begin
                state <= ST_RUN;
            end else if (handshake) begin
                state  <= ST_RUN;
                locked <= 1'b1;
            end else begin
                state <= ST_SYNC;
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_ldtu_lane_dispatcher.sv
module tb_ldtu_lane_dispatcher;
    import ldtu_pkg::*;

    localparam int NB = 32;
    localparam int NL = 4;
    localparam int FD = 8;
    localparam int W  = NB * NL;
    localparam logic [NB-1:0] SYNC_W = 32'h5A5A5A5A;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          cal  = 1'b0;
    logic          test = 1'b0;
    logic          hs   = 1'b0;
    logic [W-1:0]  atu  = '0;
    logic [W-1:0]  dout;
    logic [NL-1:0] lval;
    logic          stb;
    logic [1:0]    mode;

    ldtu_lane_dispatcher_if #(.NBITS(NB)) bus ();

    ldtu_lane_dispatcher #(.NBITS(NB), .NLANES(NL), .FRAME_DIV(FD)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .in_if            (bus),
        .CALIBRATION_BUSY (cal),
        .TEST_ENABLE      (test),
        .handshake        (hs),
        .DATA_ATU         (atu),
        .DATA_OUT         (dout),
        .lane_valid       (lval),
        .frame_stb        (stb),
        .mode             (mode)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;
    logic [NB-1:0] tx_q[$];

    // ---------------- behavioural model ----------------
    logic [1:0]    m_mode   = MODE_SYNC;
    bit            m_locked = 1'b0;
    int            m_cnt    = 0;
    bit            m_acc    = 1'b0;
    logic [NB-1:0] m_stage[$];
    logic [W-1:0]  m_out    = {NL{SYNC_W}};
    logic [NL-1:0] m_val    = '0;
    logic          m_stb    = 1'b0;
    logic [7:0]    m_fnum   = 8'd0;

    function automatic logic [NB-1:0] idle_w();
        logic [NB-1:0] w;
        w = 32'hE1E1E1E1;
`ifdef LDTU_DISP_IDLECNT_EN
        w[7:0] = m_fnum;
`endif
        return w;
    endfunction

    function automatic logic exp_ready();
        return (m_mode == MODE_RUN) && (m_stage.size() < NL) && (m_cnt != FD - 1);
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
        if (RST) begin
            m_mode = MODE_SYNC; m_locked = 0; m_cnt = 0; m_acc = 0;
            m_stage.delete(); m_out = {NL{SYNC_W}}; m_val = '0; m_stb = 0; m_fnum = 0;
        end else begin
            m_acc = bus.in_valid && exp_ready();
            if (m_acc) m_stage.push_back(bus.in_data);
            m_stb = (m_cnt == FD - 1);
            if (m_cnt == FD - 1) begin
                for (int i = 0; i < NL; i++) begin
                    m_val[i] = 1'b0;
                    if (m_mode == MODE_RUN && i < m_stage.size()) begin
                        m_out[i*NB +: NB] = m_stage[i];
                        m_val[i] = 1'b1;
                    end else if (m_mode == MODE_TEST) m_out[i*NB +: NB] = atu[i*NB +: NB];
                    else if (m_mode == MODE_SYNC)     m_out[i*NB +: NB] = SYNC_W;
                    else                              m_out[i*NB +: NB] = idle_w();
                end
                m_stage.delete();
                m_fnum = m_fnum + 8'd1;
                if (cal) begin m_mode = MODE_CAL; m_locked = 0; end
                else if (test)     m_mode = MODE_TEST;
                else if (m_locked) m_mode = MODE_RUN;
                else if (hs)       begin m_mode = MODE_RUN; m_locked = 1; end
                else               m_mode = MODE_SYNC;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    // ---------------- FIFO-side feeder ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (m_acc && tx_q.size() > 0) void'(tx_q.pop_front());
            bus.in_valid = (tx_q.size() > 0);
            bus.in_data  = (tx_q.size() > 0) ? tx_q[0] : '0;
        end
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    // Every-cycle compare against the model.
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            check("data_out",   dout,         m_out);
            check("lane_valid", lval,         m_val);
            check("frame_stb",  stb,          m_stb);
            check("mode",       mode,         m_mode);
            check("in_ready",   bus.in_ready, exp_ready());
        end
    end

    task automatic wait_stb();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FD && !seen; i++) begin
            @(negedge CLK);
            seen = (stb === 1'b1);
        end
        if (!seen) begin
            n_chk++;
            $display("FAIL stb_timeout: no frame_stb within %0d cycles, expected one every %0d", 4 * FD, FD);
        end
    endtask

    initial begin
        int c0, c1;
        logic [W-1:0] exp_v;

        // Reset state.
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("rst_data",  dout, {NL{SYNC_W}});
        check("rst_valid", lval, '0);
        check("rst_ready", bus.in_ready, 1'b0);
        check("rst_stb",   stb, 1'b0);
        RST = 1'b0;

        // Three SYNC frames without handshake.
        wait_stb(); c0 = cyc;
        check("sync_data", dout, {4{32'h5A5A5A5A}});
        wait_stb(); c1 = cyc;
        check("stb_period", c1 - c0, 8);
        wait_stb();
        check("sync_mode", mode, 2'd0);

        // Lock and stream 8 words.
        hs = 1'b1;
        wait_stb();
        check("lock_mode", mode, 2'd1);
        hs = 1'b0;
        for (int i = 0; i < 8; i++) tx_q.push_back(32'h100 + i);
        wait_stb();
        check("stream0", dout, {32'h103, 32'h102, 32'h101, 32'h100});
        check("stream0_valid", lval, 4'hF);
        wait_stb();
        check("stream1", dout, {32'h107, 32'h106, 32'h105, 32'h104});

        // Partial frame: 2 words.
        tx_q.push_back(32'h200);
        tx_q.push_back(32'h201);
        wait_stb();
        check("partial_lo", dout[63:0], {32'h201, 32'h200});
        check("partial_valid", lval, 4'b0011);
`ifndef LDTU_DISP_IDLECNT_EN
        check("partial_idle", dout[127:64], {2{32'hE1E1E1E1}});
`endif

        // TEST raised mid-frame.
        atu = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        repeat (3) @(negedge CLK);
        test = 1'b1;
        @(negedge CLK);
        check("test_wait_mode", mode, 2'd1);
        wait_stb();
        check("test_mode", mode, 2'd2);
        wait_stb();
        check("test_data", dout, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        test = 1'b0;
        wait_stb();
        check("test_to_run", mode, 2'd1);

        // Calibration with simultaneous handshake.
        cal = 1'b1; hs = 1'b1;
        wait_stb();
        check("cal_mode", mode, 2'd3);
        cal = 1'b0; hs = 1'b0;
        wait_stb();
        check("cal_idle", dout[31:8], 24'hE1E1E1);
        check("cal_exit_sync", mode, 2'd0);
        wait_stb();
        check("cal_sync_data", dout, {4{32'h5A5A5A5A}});
        hs = 1'b1;
        wait_stb();
        check("relock", mode, 2'd1);
        hs = 1'b0;

        // Reset mid-frame after two accepts.
        wait_stb();
        tx_q.push_back(32'h300);
        tx_q.push_back(32'h301);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        tx_q.delete();
        check("midrst_data",  dout, {NL{SYNC_W}});
        check("midrst_valid", lval, '0);
        wait_stb();
        check("midrst_drop0", lval, '0);
        wait_stb();
        check("midrst_drop1", lval, '0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RST = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 63) == 0) cal  = ~cal;
            if ($urandom_range(0, 31) == 0) test = ~test;
            hs = ($urandom_range(0, 3) != 0);
            if (stb) begin
                exp_v = {$urandom(), $urandom(), $urandom(), $urandom()};
                atu = exp_v;
            end
            if (tx_q.size() < 6 && $urandom_range(0, 1) == 1) tx_q.push_back($urandom());
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
